regfile_wr_arbiter: RTL and testbench

- Shares the single register-file write port (we3/a3/wd3) between two sources.
  - Source 1: the in-order pipeline writeback stage (WB). It has fixed priority and is never back-pressured.
  - Source 2: a long-latency multi-cycle unit (MC), e.g. mul/div. It uses valid/ready and is buffered in a small FIFO.
- Also provides RAW-hazard lookup against queued MC results.
- Raises a starvation stall that forces a pipeline bubble so MC results drain.

---
 rtl/regfile_wr_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter. The writeback stage always wins the port.
// Multi-cycle unit results wait in a small FIFO and drain in the free cycles.
// Queued results can also be looked up for RAW hazards. If the head result is
// blocked for too long, wb_stall forces a pipeline bubble so that it can drain.
//
// state | meaning
// IDLE  | head not blocked, starvation counter cleared
// WAIT  | valid head blocked by WB, counting consecutive blocked cycles
// FORCE | starvation limit hit, wb_stall held until the head resolves
module regfile_wr_arbiter #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            mc_valid,
  output logic            mc_ready,
  input  logic [4:0]      mc_rd,
  input  logic [XLEN-1:0] mc_data,
  output logic            rf_we,
  output logic [4:0]      rf_a3,
  output logic [XLEN-1:0] rf_wd,
  input  logic [4:0]      hz_a1,
  input  logic [4:0]      hz_a2,
  output logic            hz_stall,
  output logic            wb_stall,
  output logic            proto_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_FORCE = 2'd2;

  // Shift-register FIFO: slot 0 is always the head. Slots at or above count
  // always hold a cleared valid bit, so valid implies present.
  logic [4:0]      q_rd     [DEPTH];
  logic [XLEN-1:0] q_data   [DEPTH];
  logic [DEPTH-1:0] q_vld;
  logic [CW-1:0]   count;

  logic [4:0]      ext_rd   [DEPTH+1];
  logic [XLEN-1:0] ext_data [DEPTH+1];
  logic [DEPTH:0]  ext_vld;
  logic [4:0]      nxt_rd   [DEPTH];
  logic [XLEN-1:0] nxt_data [DEPTH];
  logic [DEPTH-1:0] nxt_vld;
  logic [DEPTH-1:0] vld_keep;
  logic [CW-1:0]   count_nxt;
  logic [CW-1:0]   wr_idx;

  logic            wb_act;
  logic            pop;
  logic            push;
  logic            push_vld;
  logic            blocked;
  logic [1:0]      state;
  logic [3:0]      starve_cnt;
  logic [3:0]      starve_inc;

  // Port ownership, handshake and the FIFO's next contents.
  always_comb begin
    wb_act    = wb_we && (wb_rd != 5'd0);
    pop       = (count != '0) && (!q_vld[0] || !wb_act);
    mc_ready  = !rst && (count < CW'(DEPTH));
    push      = mc_valid && mc_ready;
    push_vld  = (mc_rd != 5'd0) && !(wb_act && (mc_rd == wb_rd));
    wr_idx    = count - CW'(pop);
    count_nxt = count + CW'(push) - CW'(pop);
    for (int i = 0; i < DEPTH; i++) begin
      // a younger WB write to the same rd supersedes the queued result
      vld_keep[i]    = q_vld[i] && !(wb_act && (q_rd[i] == wb_rd));
      ext_rd[i]      = q_rd[i];
      ext_data[i]    = q_data[i];
    end
    ext_rd[DEPTH]   = 5'd0;
    ext_data[DEPTH] = '0;
    ext_vld         = {1'b0, vld_keep};
    for (int i = 0; i < DEPTH; i++) begin
      if (pop) begin
        nxt_rd[i]   = ext_rd[i+1];
        nxt_data[i] = ext_data[i+1];
        nxt_vld[i]  = ext_vld[i+1];
      end else begin
        nxt_rd[i]   = q_rd[i];
        nxt_data[i] = q_data[i];
        nxt_vld[i]  = vld_keep[i];
      end
      if (push && (wr_idx == CW'(i))) begin
        nxt_rd[i]   = mc_rd;
        nxt_data[i] = mc_data;
        nxt_vld[i]  = push_vld;
      end
    end
    blocked    = wb_act && vld_keep[0];
    starve_inc = starve_cnt + 4'd1;
  end

  // Write-port mux: WB first, then a valid FIFO head.
  always_comb begin
    rf_we = 1'b0;
    rf_a3 = 5'd0;
    rf_wd = '0;
    if (!rst) begin
      if (wb_act) begin
        rf_we = 1'b1;
        rf_a3 = wb_rd;
        rf_wd = wb_data;
      end else if (q_vld[0]) begin
        rf_we = 1'b1;
        rf_a3 = q_rd[0];
        rf_wd = q_data[0];
      end
    end
  end

  // RAW lookup against queued results, using the pre-supersede valid bits.
  always_comb begin
    hz_stall = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld[i] && (((hz_a1 != 5'd0) && (q_rd[i] == hz_a1)) ||
                       ((hz_a2 != 5'd0) && (q_rd[i] == hz_a2))))
        hz_stall = 1'b1;
    end
    if (rst) hz_stall = 1'b0;
  end

  // FIFO storage and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      q_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_rd[i]   <= 5'd0;
        q_data[i] <= '0;
      end
    end else begin
      count <= count_nxt;
      q_vld <= nxt_vld;
      for (int i = 0; i < DEPTH; i++) begin
        q_rd[i]   <= nxt_rd[i];
        q_data[i] <= nxt_data[i];
      end
    end
  end

  // Starvation FSM and the sticky protocol-error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      starve_cnt <= 4'd0;
      wb_stall   <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      if (wb_stall && wb_act) proto_err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (blocked) begin
            starve_cnt <= 4'd1;
            if (STARVE_LIMIT <= 1) begin
              state    <= ST_FORCE;
              wb_stall <= 1'b1;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (blocked) begin
            starve_cnt <= starve_inc;
            if (starve_inc >= 4'(STARVE_LIMIT)) begin
              state    <= ST_FORCE;
              wb_stall <= 1'b1;
            end
          end else begin
            state      <= ST_IDLE;
            starve_cnt <= 4'd0;
          end
        end
        ST_FORCE: begin
          if (!blocked) begin
            state      <= ST_IDLE;
            starve_cnt <= 4'd0;
            wb_stall   <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          starve_cnt <= 4'd0;
          wb_stall   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: a queue-based model checked every negedge,
// plus directed scenarios with hand-computed expectations.
module tb_regfile_wr_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            mc_valid;
  logic            mc_ready;
  logic [4:0]      mc_rd;
  logic [XLEN-1:0] mc_data;
  logic            rf_we;
  logic [4:0]      rf_a3;
  logic [XLEN-1:0] rf_wd;
  logic [4:0]      hz_a1;
  logic [4:0]      hz_a2;
  logic            hz_stall;
  logic            wb_stall;
  logic            proto_err;

  regfile_wr_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_data(mc_data),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd),
    .hz_a1(hz_a1), .hz_a2(hz_a2), .hz_stall(hz_stall),
    .wb_stall(wb_stall), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    bit              vld;
  } ent_t;

  ent_t            mq[$];
  bit              m_stall;
  bit              m_perr;
  int              m_run;
  logic [XLEN-1:0] shadow [32];

  // Model: queue of pending results, run length of blocked cycles.
  always @(negedge clk) begin : model_cmp
    bit wact, ready, hz, blk, pop, ewe;
    logic [4:0] ea3;
    logic [XLEN-1:0] ewd;
    if (rst) begin
      mq.delete();
      m_stall = 0;
      m_perr  = 0;
      m_run   = 0;
      chk("m_rst_mc_ready", {31'd0, mc_ready}, 32'd0);
      chk("m_rst_rf_we", {31'd0, rf_we}, 32'd0);
      chk("m_rst_hz_stall", {31'd0, hz_stall}, 32'd0);
      chk("m_rst_wb_stall", {31'd0, wb_stall}, 32'd0);
      chk("m_rst_proto_err", {31'd0, proto_err}, 32'd0);
    end else begin
      wact  = wb_we && (wb_rd != 0);
      ready = mq.size() < DEPTH;
      hz = 0;
      foreach (mq[i])
        if (mq[i].vld && ((hz_a1 != 0 && mq[i].rd == hz_a1) || (hz_a2 != 0 && mq[i].rd == hz_a2)))
          hz = 1;
      ewe = 0; ea3 = 0; ewd = 0;
      if (wact) begin
        ewe = 1; ea3 = wb_rd; ewd = wb_data;
      end else if (mq.size() > 0 && mq[0].vld) begin
        ewe = 1; ea3 = mq[0].rd; ewd = mq[0].data;
      end
      chk("m_mc_ready", {31'd0, mc_ready}, {31'd0, ready});
      chk("m_rf_we", {31'd0, rf_we}, {31'd0, ewe});
      chk("m_rf_a3", {27'd0, rf_a3}, {27'd0, ea3});
      chk("m_rf_wd", rf_wd, ewd);
      chk("m_hz_stall", {31'd0, hz_stall}, {31'd0, hz});
      chk("m_wb_stall", {31'd0, wb_stall}, {31'd0, m_stall});
      chk("m_proto_err", {31'd0, proto_err}, {31'd0, m_perr});
      if (rf_we) shadow[rf_a3] = rf_wd;
      blk = wact && mq.size() > 0 && mq[0].vld && (mq[0].rd != wb_rd);
      pop = mq.size() > 0 && (!mq[0].vld || !wact);
      if (wact && m_stall) m_perr = 1;
      m_run   = blk ? m_run + 1 : 0;
      m_stall = blk && (m_run >= LIMIT);
      if (pop) void'(mq.pop_front());
      if (wact) foreach (mq[i]) if (mq[i].rd == wb_rd) mq[i].vld = 0;
      if (mc_valid && ready)
        mq.push_back('{mc_rd, mc_data, (mc_rd != 0) && !(wact && mc_rd == wb_rd)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    wb_we = 0; wb_rd = 0; wb_data = 0;
    mc_valid = 0; mc_rd = 0; mc_data = 0;
    hz_a1 = 0; hz_a2 = 0;
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_mc_ready", {31'd0, mc_ready}, 32'd0);
    chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset_wb_stall", {31'd0, wb_stall}, 32'd0);
    chk("reset_proto_err", {31'd0, proto_err}, 32'd0);
    rst = 0;

    // single MC result
    mc_valid = 1; mc_rd = 5; mc_data = 32'hDEADBEEF; hz_a1 = 5;
    #1;
    chk("t1_ready_c0", {31'd0, mc_ready}, 32'd1);
    chk("t1_hz_c0", {31'd0, hz_stall}, 32'd0);
    chk("t1_we_c0", {31'd0, rf_we}, 32'd0);
    tick();
    mc_valid = 0;
    #1;
    chk("t1_we_c1", {31'd0, rf_we}, 32'd1);
    chk("t1_a3_c1", {27'd0, rf_a3}, 32'd5);
    chk("t1_wd_c1", rf_wd, 32'hDEADBEEF);
    chk("t1_hz_c1", {31'd0, hz_stall}, 32'd1);
    tick();
    chk("t1_we_c2", {31'd0, rf_we}, 32'd0);
    chk("t1_hz_c2", {31'd0, hz_stall}, 32'd0);
    hz_a1 = 0;

    // WB priority with FIFO filling to full
    wb_we = 1; wb_rd = 1; wb_data = 32'h100;
    mc_valid = 1; mc_rd = 6; mc_data = 32'd1;
    tick();
    wb_rd = 2; wb_data = 32'h200; mc_rd = 7; mc_data = 32'd2;
    tick();
    mc_valid = 0; wb_rd = 3; wb_data = 32'h300;
    #1;
    chk("t2_ready_full", {31'd0, mc_ready}, 32'd0);
    chk("t2_wb_a3", {27'd0, rf_a3}, 32'd3);
    chk("t2_wb_wd", rf_wd, 32'h300);
    tick();
    wb_we = 0; wb_rd = 0; wb_data = 0;
    #1;
    chk("t2_drain0_a3", {27'd0, rf_a3}, 32'd6);
    chk("t2_drain0_wd", rf_wd, 32'd1);
    tick();
    chk("t2_drain1_a3", {27'd0, rf_a3}, 32'd7);
    chk("t2_drain1_wd", rf_wd, 32'd2);
    tick();
    chk("t2_empty_we", {31'd0, rf_we}, 32'd0);

    // WAW supersede
    mc_valid = 1; mc_rd = 8; mc_data = 32'h11; hz_a1 = 8;
    tick();
    mc_valid = 0; wb_we = 1; wb_rd = 8; wb_data = 32'h22;
    #1;
    chk("t3_hz_same_cycle", {31'd0, hz_stall}, 32'd1);
    chk("t3_wb_wd", rf_wd, 32'h22);
    tick();
    wb_we = 0; wb_rd = 0; wb_data = 0;
    #1;
    chk("t3_hz_after", {31'd0, hz_stall}, 32'd0);
    chk("t3_no_stale_we", {31'd0, rf_we}, 32'd0);
    tick();
    chk("t3_no_stale_we2", {31'd0, rf_we}, 32'd0);
    chk("t3_x8_final", shadow[8], 32'h22);
    hz_a1 = 0;

    // x0 handling
    mc_valid = 1; mc_rd = 10; mc_data = 32'hA;
    tick();
    mc_valid = 0; wb_we = 1; wb_rd = 0; wb_data = 32'h55;
    #1;
    chk("t4_x0_drain_we", {31'd0, rf_we}, 32'd1);
    chk("t4_x0_drain_a3", {27'd0, rf_a3}, 32'd10);
    chk("t4_x0_drain_wd", rf_wd, 32'hA);
    tick();
    wb_we = 0; wb_data = 0;
    mc_valid = 1; mc_rd = 0; mc_data = 32'h77;
    tick();
    mc_valid = 0;
    #1;
    chk("t4_mc_x0_we", {31'd0, rf_we}, 32'd0);
    chk("t4_hz_x0", {31'd0, hz_stall}, 32'd0);
    tick();
    chk("t4_ready_after", {31'd0, mc_ready}, 32'd1);

    // starvation, pipeline honours wb_stall
    mc_valid = 1; mc_rd = 9; mc_data = 32'h99;
    wb_we = 1; wb_rd = 1; wb_data = 32'h1;
    tick();
    mc_valid = 0; wb_rd = 2; wb_data = 32'h2;
    for (int k = 1; k <= LIMIT; k++) begin
      chk("t5_stall_pre", {31'd0, wb_stall}, 32'd0);
      tick();
    end
    chk("t5_stall_set", {31'd0, wb_stall}, 32'd1);
    wb_we = 0; wb_rd = 0; wb_data = 0;
    #1;
    chk("t5_x9_we", {31'd0, rf_we}, 32'd1);
    chk("t5_x9_a3", {27'd0, rf_a3}, 32'd9);
    chk("t5_x9_wd", rf_wd, 32'h99);
    tick();
    chk("t5_stall_clr", {31'd0, wb_stall}, 32'd0);
    chk("t5_proto_ok", {31'd0, proto_err}, 32'd0);

    // starvation, pipeline ignores wb_stall
    mc_valid = 1; mc_rd = 9; mc_data = 32'h98;
    wb_we = 1; wb_rd = 1; wb_data = 32'h1;
    tick();
    mc_valid = 0; wb_rd = 2; wb_data = 32'h2;
    repeat (LIMIT) tick();
    chk("t6_stall_set", {31'd0, wb_stall}, 32'd1);
    chk("t6_proto_pre", {31'd0, proto_err}, 32'd0);
    chk("t6_wb_wins", {27'd0, rf_a3}, 32'd2);
    tick();
    chk("t6_proto_set", {31'd0, proto_err}, 32'd1);
    chk("t6_stall_held", {31'd0, wb_stall}, 32'd1);
    wb_we = 0; wb_rd = 0; wb_data = 0;
    tick();
    chk("t6_stall_clr", {31'd0, wb_stall}, 32'd0);
    chk("t6_proto_sticky", {31'd0, proto_err}, 32'd1);
    tick();
    chk("t6_proto_sticky2", {31'd0, proto_err}, 32'd1);

    // async reset with two queued entries
    wb_we = 1; wb_rd = 1; wb_data = 32'h1;
    mc_valid = 1; mc_rd = 11; mc_data = 32'hB;
    tick();
    mc_rd = 12; mc_data = 32'hC;
    tick();
    mc_valid = 0; hz_a1 = 11;
    #1;
    chk("t7_full_pre", {31'd0, mc_ready}, 32'd0);
    chk("t7_hz_pre", {31'd0, hz_stall}, 32'd1);
    rst = 1;
    #1;
    chk("t7_rst_ready", {31'd0, mc_ready}, 32'd0);
    chk("t7_rst_we", {31'd0, rf_we}, 32'd0);
    chk("t7_rst_hz", {31'd0, hz_stall}, 32'd0);
    chk("t7_rst_proto", {31'd0, proto_err}, 32'd0);
    tick();
    rst = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
    #1;
    chk("t7_ready_after", {31'd0, mc_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("t7_no_write", {31'd0, rf_we}, 32'd0);
      tick();
    end
    hz_a1 = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
